// File: rtl/spiflash_resp_pkg.sv
// Shared types and constants for the SPI flash responder.
package spiflash_resp_pkg;

   localparam logic [7:0] CMD_READ      = 8'h03;
   localparam logic [7:0] CMD_FAST_READ = 8'h0B;
   localparam logic [7:0] CMD_JEDEC     = 8'h9F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA,
      ST_ID,
      ST_IGNORE
   } state_e;

   typedef enum logic [1:0] {
      TGT_NONE,
      TGT_CUR,
      TGT_NXT
   } tgt_e;

   function automatic logic [31:0] word_addr(
      input logic [31:0] base,
      input logic [21:0] widx
   );
      return base + {8'h00, widx, 2'b00};
   endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronisers for the SPI pins plus SCK edge detection.
module spi_pin_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic spi_csb_i,
   input  logic spi_clk_i,
   input  logic spi_mosi_i,
   output logic csb_s,
   output logic clk_rise,
   output logic clk_fall,
   output logic mosi_s
);

   logic [1:0] csb_q, csb_d;
   logic [1:0] sck_q, sck_d;
   logic [1:0] mosi_q, mosi_d;
   logic       sck_prev_q, sck_prev_d;

   always_comb begin
      csb_d      = {csb_q[0], spi_csb_i};
      sck_d      = {sck_q[0], spi_clk_i};
      mosi_d     = {mosi_q[0], spi_mosi_i};
      sck_prev_d = sck_q[1];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         csb_q      <= 2'b11;
         sck_q      <= 2'b11;
         mosi_q     <= 2'b00;
         sck_prev_q <= 1'b1;
      end else begin
         csb_q      <= csb_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         sck_prev_q <= sck_prev_d;
      end
   end

   assign csb_s    = csb_q[1];
   assign mosi_s   = mosi_q[1];
   assign clk_rise = sck_q[1] & ~sck_prev_q;
   assign clk_fall = ~sck_q[1] & sck_prev_q;

endmodule

// File: rtl/spiflash_responder_wb.sv
// SPI NOR-flash read target backed by a Wishbone classic read master.
// Define SPIFLASH_RESP_FAST_READ_EN to accept 0x0B with dummy cycles.
module spiflash_responder_wb
   import spiflash_resp_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter logic [23:0] JEDEC_ID     = 24'hEF4018,
   parameter int unsigned DUMMY_CYCLES = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        spi_csb_i,
   input  logic        spi_clk_i,
   input  logic        spi_mosi_i,
   output logic        spi_miso_o,
   output logic        spi_miso_oe,
   output logic [31:0] wb_adr_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   output logic        underrun_o
);

   logic csb_s, clk_rise, clk_fall, mosi_s;

   spi_pin_sync u_sync (
      .clk_i      (wb_clk_i),
      .rst_ni     (wb_rst_ni),
      .spi_csb_i  (spi_csb_i),
      .spi_clk_i  (spi_clk_i),
      .spi_mosi_i (spi_mosi_i),
      .csb_s      (csb_s),
      .clk_rise   (clk_rise),
      .clk_fall   (clk_fall),
      .mosi_s     (mosi_s)
   );

   state_e      state_q, state_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [23:0] addr_q, addr_d;
   logic [31:0] cur_w_q, cur_w_d;
   logic [31:0] nxt_w_q, nxt_w_d;
   logic        cur_v_q, cur_v_d;
   logic        nxt_v_q, nxt_v_d;
   logic        cur_req_q, cur_req_d;
   logic        pf_req_q, pf_req_d;
   tgt_e        tgt_q, tgt_d;
   logic        cyc_q, cyc_d;
   logic [31:0] adr_q, adr_d;
   logic        miso_q, miso_d;
   logic        oe_q, oe_d;
   logic        und_q, und_d;
   logic [1:0]  lane;
   logic [7:0]  byte_v;
`ifdef SPIFLASH_RESP_FAST_READ_EN
   logic        fast_q, fast_d;
   logic [7:0]  dum_q, dum_d;
`else
   logic        unused_dummy;
   assign unused_dummy = (DUMMY_CYCLES == 0);
`endif

   assign lane = addr_q[1:0];

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      cmd_d     = cmd_q;
      addr_d    = addr_q;
      cur_w_d   = cur_w_q;
      nxt_w_d   = nxt_w_q;
      cur_v_d   = cur_v_q;
      nxt_v_d   = nxt_v_q;
      cur_req_d = cur_req_q;
      pf_req_d  = pf_req_q;
      tgt_d     = tgt_q;
      cyc_d     = cyc_q;
      adr_d     = adr_q;
      miso_d    = miso_q;
      oe_d      = oe_q;
      und_d     = 1'b0;
      byte_v    = 8'h00;
`ifdef SPIFLASH_RESP_FAST_READ_EN
      fast_d    = fast_q;
      dum_d     = dum_q;
`endif

      if (cyc_q && wb_ack_i) begin
         cyc_d = 1'b0;
         tgt_d = TGT_NONE;
         if (tgt_q == TGT_CUR) begin
            cur_w_d = wb_dat_i;
            cur_v_d = 1'b1;
         end else if (tgt_q == TGT_NXT) begin
            nxt_w_d = wb_dat_i;
            nxt_v_d = 1'b1;
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (!csb_s) begin
               state_d   = ST_CMD;
               bit_cnt_d = 5'd0;
            end
         end
         ST_CMD: begin
            if (clk_rise) begin
               cmd_d     = {cmd_q[6:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd7) begin
                  bit_cnt_d = 5'd0;
                  case (cmd_d)
                     CMD_READ: begin
                        state_d = ST_ADDR;
`ifdef SPIFLASH_RESP_FAST_READ_EN
                        fast_d  = 1'b0;
`endif
                     end
`ifdef SPIFLASH_RESP_FAST_READ_EN
                     CMD_FAST_READ: begin
                        state_d = ST_ADDR;
                        fast_d  = 1'b1;
                     end
`endif
                     CMD_JEDEC: begin
                        state_d = ST_ID;
                        oe_d    = 1'b1;
                     end
                     default: state_d = ST_IGNORE;
                  endcase
               end
            end
         end
         ST_ADDR: begin
            if (clk_rise) begin
               addr_d    = {addr_q[22:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd23) begin
                  bit_cnt_d = 5'd0;
                  cur_v_d   = 1'b0;
                  nxt_v_d   = 1'b0;
                  cur_req_d = 1'b1;
                  pf_req_d  = 1'b0;
                  state_d   = ST_DATA;
                  oe_d      = 1'b1;
`ifdef SPIFLASH_RESP_FAST_READ_EN
                  if (fast_q) begin
                     state_d = ST_DUMMY;
                     oe_d    = 1'b0;
                     dum_d   = 8'd0;
                  end
`endif
               end
            end
         end
`ifdef SPIFLASH_RESP_FAST_READ_EN
         ST_DUMMY: begin
            if (clk_rise) begin
               dum_d = dum_q + 8'd1;
               if (dum_q == 8'(DUMMY_CYCLES - 1)) begin
                  state_d = ST_DATA;
                  oe_d    = 1'b1;
               end
            end
         end
`endif
         ST_DATA: begin
            if (clk_fall) begin
               byte_v = cur_w_d[{lane, 3'b000} +: 8];
               if (cur_v_d) begin
                  miso_d = byte_v[3'd7 - bit_cnt_q[2:0]];
               end else begin
                  miso_d = 1'b1;
                  und_d  = 1'b1;
               end
               if (lane == 2'd3 && bit_cnt_q[2:0] == 3'd0 &&
                   !nxt_v_d && tgt_d != TGT_NXT) begin
                  pf_req_d = 1'b1;
               end
               if (bit_cnt_q[2:0] == 3'd7) begin
                  bit_cnt_d = 5'd0;
                  addr_d    = addr_q + 24'd1;
                  // Word boundary: promote next, retarget its fetch.
                  if (lane == 2'd3) begin
                     cur_w_d = nxt_w_d;
                     cur_v_d = nxt_v_d;
                     nxt_v_d = 1'b0;
                     if (tgt_d == TGT_NXT) begin
                        tgt_d = TGT_CUR;
                     end else if (tgt_d == TGT_CUR) begin
                        tgt_d = TGT_NONE;
                     end
                     if (pf_req_d) begin
                        pf_req_d  = 1'b0;
                        cur_req_d = 1'b1;
                     end
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end
         ST_ID: begin
            if (clk_fall) begin
               miso_d = 1'b1;
               if (bit_cnt_q < 5'd24) begin
                  miso_d    = JEDEC_ID[5'd23 - bit_cnt_q];
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end
         ST_IGNORE: begin
         end
         default: state_d = ST_IDLE;
      endcase

      if (csb_s) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 5'd0;
         oe_d      = 1'b0;
         miso_d    = 1'b1;
         cur_v_d   = 1'b0;
         nxt_v_d   = 1'b0;
         cur_req_d = 1'b0;
         pf_req_d  = 1'b0;
         tgt_d     = TGT_NONE;
         und_d     = 1'b0;
      end

      if (!cyc_q) begin
         if (cur_req_d) begin
            cyc_d     = 1'b1;
            adr_d     = word_addr(BASE_ADDR, addr_d[23:2]);
            tgt_d     = TGT_CUR;
            cur_req_d = 1'b0;
         end else if (pf_req_d) begin
            cyc_d    = 1'b1;
            adr_d    = word_addr(BASE_ADDR, addr_d[23:2] + 22'd1);
            tgt_d    = TGT_NXT;
            pf_req_d = 1'b0;
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 5'd0;
         cmd_q     <= 8'h00;
         addr_q    <= 24'h0;
         cur_w_q   <= 32'h0;
         nxt_w_q   <= 32'h0;
         cur_v_q   <= 1'b0;
         nxt_v_q   <= 1'b0;
         cur_req_q <= 1'b0;
         pf_req_q  <= 1'b0;
         tgt_q     <= TGT_NONE;
         cyc_q     <= 1'b0;
         adr_q     <= 32'h0;
         miso_q    <= 1'b1;
         oe_q      <= 1'b0;
         und_q     <= 1'b0;
`ifdef SPIFLASH_RESP_FAST_READ_EN
         fast_q    <= 1'b0;
         dum_q     <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         cmd_q     <= cmd_d;
         addr_q    <= addr_d;
         cur_w_q   <= cur_w_d;
         nxt_w_q   <= nxt_w_d;
         cur_v_q   <= cur_v_d;
         nxt_v_q   <= nxt_v_d;
         cur_req_q <= cur_req_d;
         pf_req_q  <= pf_req_d;
         tgt_q     <= tgt_d;
         cyc_q     <= cyc_d;
         adr_q     <= adr_d;
         miso_q    <= miso_d;
         oe_q      <= oe_d;
         und_q     <= und_d;
`ifdef SPIFLASH_RESP_FAST_READ_EN
         fast_q    <= fast_d;
         dum_q     <= dum_d;
`endif
      end
   end

   assign spi_miso_o  = miso_q;
   assign spi_miso_oe = oe_q;
   assign wb_adr_o    = adr_q;
   assign wb_cyc_o    = cyc_q;
   assign wb_stb_o    = cyc_q;
   assign underrun_o  = und_q;

endmodule
